// File: rtl/mem_arb_pkg.sv
// Shared definitions for the single-port RAM access sequencer:
// FSM state encodings, requester indices, counter width and a
// one-hot-to-index helper.
package mem_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam int CNT_W   = 3;   // holds RAM_LAT up to 7

    // FSM state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef logic [1:0]         req_idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    // Requester indices; also the bit positions inside a req_vec_t
    localparam req_idx_t REQ_FETCH = 2'd0;
    localparam req_idx_t REQ_DATA  = 2'd1;
    localparam req_idx_t REQ_LDR   = 2'd2;

    // Convert a one-hot grant into a requester index (fetch if none set)
    function automatic req_idx_t gnt_to_idx(input req_vec_t gnt);
        req_idx_t idx;
        idx = REQ_FETCH;
        if (gnt[REQ_LDR])       idx = REQ_LDR;
        else if (gnt[REQ_DATA]) idx = REQ_DATA;
        return idx;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side bundle of the memory arbiter.
// slave  : the arbiter's view (takes requests, drives the RAM port)
// master : the environment's view (requesters plus the RAM itself)
interface mem_arbiter_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
);
    // instruction fetch (read only)
    logic              fetch_req;
    logic [AWIDTH-1:0] fetch_addr;
    logic              fetch_done;
    // data load/store
    logic              data_req;
    logic              data_we;
    logic [AWIDTH-1:0] data_addr;
    logic [DWIDTH-1:0] data_wdata;
    logic              data_done;
    // program loader (write only)
    logic              ldr_req;
    logic [AWIDTH-1:0] ldr_addr;
    logic [DWIDTH-1:0] ldr_wdata;
    logic              ldr_done;
    // shared read return and status
    logic [DWIDTH-1:0] rdata;
    logic              busy;
    // RAM port
    logic              ram_en;
    logic              ram_we;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_wdata;
    logic [DWIDTH-1:0] ram_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        input  data_req, data_we, data_addr, data_wdata,
        input  ldr_req, ldr_addr, ldr_wdata,
        input  ram_rdata,
        output fetch_done, data_done, ldr_done,
        output rdata, busy,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output fetch_req, fetch_addr,
        output data_req, data_we, data_addr, data_wdata,
        output ldr_req, ldr_addr, ldr_wdata,
        output ram_rdata,
        input  fetch_done, data_done, ldr_done,
        input  rdata, busy,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// Default build: fixed priority ldr > data > fetch.
// With MEM_ARB_RR_EN defined: round robin in the cyclic order
// ldr -> data -> fetch -> ldr, the last winner being lowest priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  req_vec_t req_i,
    input  req_idx_t last_i,
    output req_vec_t gnt_o
);

`ifdef MEM_ARB_RR_EN
    // priority order starts with the requester that follows last_i
    always_comb begin
        gnt_o = '0;
        case (last_i)
            REQ_LDR: begin
                if (req_i[REQ_DATA])       gnt_o[REQ_DATA]  = 1'b1;
                else if (req_i[REQ_FETCH]) gnt_o[REQ_FETCH] = 1'b1;
                else if (req_i[REQ_LDR])   gnt_o[REQ_LDR]   = 1'b1;
            end
            REQ_DATA: begin
                if (req_i[REQ_FETCH])      gnt_o[REQ_FETCH] = 1'b1;
                else if (req_i[REQ_LDR])   gnt_o[REQ_LDR]   = 1'b1;
                else if (req_i[REQ_DATA])  gnt_o[REQ_DATA]  = 1'b1;
            end
            default: begin  // last = fetch (also the reset value)
                if (req_i[REQ_LDR])        gnt_o[REQ_LDR]   = 1'b1;
                else if (req_i[REQ_DATA])  gnt_o[REQ_DATA]  = 1'b1;
                else if (req_i[REQ_FETCH]) gnt_o[REQ_FETCH] = 1'b1;
            end
        endcase
    end
`else
    // last winner is irrelevant for fixed priority
    logic unused_last;
    assign unused_last = ^last_i;

    // fixed priority ldr > data > fetch
    always_comb begin
        gnt_o = '0;
        if (req_i[REQ_LDR])        gnt_o[REQ_LDR]   = 1'b1;
        else if (req_i[REQ_DATA])  gnt_o[REQ_DATA]  = 1'b1;
        else if (req_i[REQ_FETCH]) gnt_o[REQ_FETCH] = 1'b1;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM access sequencer for the 16-bit core.
// Shares one RAM port between instruction fetch, data load/store and
// the program loader: grants one request, issues a one-cycle RAM
// strobe, waits out the read latency and returns a one-cycle done.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration
// (adds a last-granted pointer); otherwise fixed ldr > data > fetch.
// Note: rst_n is a synchronous ACTIVE-HIGH reset (name kept for
// port consistency across the core).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 8,
    parameter int RAM_LAT = 1     // legal range 1..7
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    // Everything captured at grant time; request inputs are ignored after
    typedef struct packed {
        req_idx_t          win;
        logic              we;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] wdata;
    } lat_t;

    logic [1:0]        state_q, state_d;
    lat_t              lat_q, lat_d;
    cnt_t              cnt_q, cnt_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;

    req_vec_t req_vec;
    req_vec_t gnt;
    req_idx_t last_idx;
    logic     grant;

    assign req_vec = {bus.ldr_req, bus.data_req, bus.fetch_req};
    assign grant   = (state_q == IDLE) && (|req_vec);

    mem_arb_pick u_pick (
        .req_i  (req_vec),
        .last_i (last_idx),
        .gnt_o  (gnt)
    );

`ifdef MEM_ARB_RR_EN
    req_idx_t last_q;

    // remember the most recent winner; moves only when a grant happens
    always_ff @(posedge clk) begin
        if (rst_n)      last_q <= REQ_FETCH;
        else if (grant) last_q <= gnt_to_idx(gnt);
    end

    assign last_idx = last_q;
`else
    assign last_idx = REQ_FETCH;
`endif

    // next-state: IDLE samples/latches, ISSUE strobes, WAIT counts, RESP acks
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = ISSUE;
                    lat_d.win = gnt_to_idx(gnt);
                    if (gnt[REQ_LDR]) begin
                        lat_d.we    = 1'b1;
                        lat_d.addr  = bus.ldr_addr;
                        lat_d.wdata = bus.ldr_wdata;
                    end else if (gnt[REQ_DATA]) begin
                        lat_d.we    = bus.data_we;
                        lat_d.addr  = bus.data_addr;
                        lat_d.wdata = bus.data_wdata;
                    end else begin
                        // fetch is a pure read; wdata keeps its last value
                        lat_d.we    = 1'b0;
                        lat_d.addr  = bus.fetch_addr;
                    end
                end
            end
            ISSUE: begin
                if (lat_q.we) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_t'(RAM_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - cnt_t'(1);
                // counter at 1 marks the cycle RAM data is valid
                if (cnt_q == cnt_t'(1)) begin
                    rdata_d = bus.ram_rdata;
                    state_d = RESP;
                end
            end
            default: begin  // RESP
                state_d = IDLE;
            end
        endcase
    end

    // state registers; reset drops any in-flight request
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM port is driven straight from the latched request
    assign bus.ram_en    = (state_q == ISSUE);
    assign bus.ram_we    = (state_q == ISSUE) && lat_q.we;
    assign bus.ram_addr  = lat_q.addr;
    assign bus.ram_wdata = lat_q.wdata;

    // status and completion strobes
    assign bus.busy       = (state_q != IDLE);
    assign bus.rdata      = rdata_q;
    assign bus.fetch_done = (state_q == RESP) && (lat_q.win == REQ_FETCH);
    assign bus.data_done  = (state_q == RESP) && (lat_q.win == REQ_DATA);
    assign bus.ldr_done   = (state_q == RESP) && (lat_q.win == REQ_LDR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM_LAT=1 and RAM_LAT=3), a
// latency-accurate RAM model per instance, a transaction-level reference
// model checked every cycle, and directed tests with literal expectations.
module tb_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    // per-instance stimulus and observation
    logic [1:0]    f_req = '0, d_req = '0, d_we = '0, l_req = '0;
    logic [AW-1:0] f_addr [2], d_addr [2], l_addr [2];
    logic [DW-1:0] d_wdata [2], l_wdata [2];
    logic [1:0]    f_done, d_done, l_done, busy, ram_en, ram_we;
    logic [DW-1:0] rdata [2], ram_wdata [2];
    logic [DW-1:0] ram_rdata [2];
    logic [AW-1:0] ram_addr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        mem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
        assign bus.fetch_req  = f_req[g];
        assign bus.fetch_addr = f_addr[g];
        assign bus.data_req   = d_req[g];
        assign bus.data_we    = d_we[g];
        assign bus.data_addr  = d_addr[g];
        assign bus.data_wdata = d_wdata[g];
        assign bus.ldr_req    = l_req[g];
        assign bus.ldr_addr   = l_addr[g];
        assign bus.ldr_wdata  = l_wdata[g];
        assign bus.ram_rdata  = ram_rdata[g];
        assign f_done[g]      = bus.fetch_done;
        assign d_done[g]      = bus.data_done;
        assign l_done[g]      = bus.ldr_done;
        assign busy[g]        = bus.busy;
        assign rdata[g]       = bus.rdata;
        assign ram_en[g]      = bus.ram_en;
        assign ram_we[g]      = bus.ram_we;
        assign ram_addr[g]    = bus.ram_addr;
        assign ram_wdata[g]   = bus.ram_wdata;
        mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .RAM_LAT(L)) dut (
            .clk   (clk),
            .rst_n (rst),
            .bus   (bus)
        );
    end

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // ---------------- RAM model (one per instance) ----------------
    logic [DW-1:0] ram [2][256];
    int            rd_at [2] = '{-100, -100};
    logic [DW-1:0] rd_val [2];

    initial begin
        ram_rdata[0] = '0;
        ram_rdata[1] = '0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (ram_en[g]) begin
                    if (ram_we[g]) ram[g][ram_addr[g]] = ram_wdata[g];
                    else begin
                        rd_at[g]  = cyc + lat(g);
                        rd_val[g] = ram[g][ram_addr[g]];
                    end
                end
                ram_rdata[g] = (cyc == rd_at[g]) ? rd_val[g] : 16'hDEAD;
            end
        end
    end

    // ---------------- reference model ----------------
    // A granted transaction in cycle t0 has strobe at t0+1 and done at
    // t0+2 (write) or t0+2+LAT (read); read data visible from the done cycle.
    logic [DW-1:0] sh [2][256];
    bit            m_act [2];
    int            m_t0 [2], m_win [2], m_last [2];
    logic [AW-1:0] m_addr [2];
    logic          m_we [2];
    logic [DW-1:0] m_wd [2], m_rd [2];

    function automatic int pick(input logic [2:0] r, input int last);
`ifdef MEM_ARB_RR_EN
        for (int i = 1; i <= 3; i++) begin
            int c = (last + 3 - i) % 3;   // ldr(2) -> data(1) -> fetch(0)
            if (r[c]) return c;
        end
        return last;
`else
        if (r[2]) return 2;
        if (r[1]) return 1;
        return last * 0;
`endif
    endfunction

    function automatic int dur(input int g);
        return m_we[g] ? 2 : 2 + lat(g);
    endfunction

    initial forever begin
        @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                m_act[g] = 0; m_rd[g] = '0; m_last[g] = 0;
            end else if (!m_act[g]) begin
                if ({l_req[g], d_req[g], f_req[g]} != 3'b000) begin
                    m_win[g]  = pick({l_req[g], d_req[g], f_req[g]}, m_last[g]);
                    m_last[g] = m_win[g];
                    m_act[g]  = 1;
                    m_t0[g]   = cyc;
                    case (m_win[g])
                        0: begin m_addr[g] = f_addr[g]; m_we[g] = 1'b0; end
                        1: begin m_addr[g] = d_addr[g]; m_we[g] = d_we[g]; m_wd[g] = d_wdata[g]; end
                        default: begin m_addr[g] = l_addr[g]; m_we[g] = 1'b1; m_wd[g] = l_wdata[g]; end
                    endcase
                end
            end else begin
                if (cyc - m_t0[g] == 1 && m_we[g]) sh[g][m_addr[g]] = m_wd[g];
                if (!m_we[g] && cyc - m_t0[g] == 1 + lat(g)) m_rd[g] = sh[g][m_addr[g]];
                if (cyc - m_t0[g] == dur(g)) m_act[g] = 0;
            end
        end
        cyc++;
    end

    // compare DUT against the model every cycle
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                int k;
                logic [2:0] ed;
                k  = cyc - m_t0[g];
                ed = (m_act[g] && k == dur(g)) ? (3'b001 << m_win[g]) : 3'b000;
                chk("mdl_busy", 32'(busy[g]), 32'(m_act[g]));
                chk("mdl_ram_en", 32'(ram_en[g]), 32'(m_act[g] && k == 1));
                chk("mdl_ram_we", 32'(ram_we[g]), 32'(m_act[g] && k == 1 && m_we[g]));
                chk("mdl_done", 32'({l_done[g], d_done[g], f_done[g]}), 32'(ed));
                chk("mdl_rdata", 32'(rdata[g]), 32'(m_rd[g]));
                if (m_act[g] && k == 1) begin
                    chk("mdl_ram_addr", 32'(ram_addr[g]), 32'(m_addr[g]));
                    if (m_we[g]) chk("mdl_ram_wdata", 32'(ram_wdata[g]), 32'(m_wd[g]));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int g, input int p, input logic [AW-1:0] a,
                         input logic we, input logic [DW-1:0] wd);
        case (p)
            0: begin f_req[g] = 1'b1; f_addr[g] = a; end
            1: begin d_req[g] = 1'b1; d_addr[g] = a; d_we[g] = we; d_wdata[g] = wd; end
            default: begin l_req[g] = 1'b1; l_addr[g] = a; l_wdata[g] = wd; end
        endcase
    endtask

    task automatic drop(input int g, input int p);
        case (p)
            0: f_req[g] = 1'b0;
            1: d_req[g] = 1'b0;
            default: l_req[g] = 1'b0;
        endcase
    endtask

    function automatic logic done_of(input int g, input int p);
        case (p)
            0: return f_done[g];
            1: return d_done[g];
            default: return l_done[g];
        endcase
    endfunction

    task automatic preload(input int g, input logic [AW-1:0] a, input logic [DW-1:0] v);
        ram[g][a] = v;
        sh[g][a]  = v;
    endtask

    // single transaction from an idle arbiter; D is the hand-computed done cycle
    task automatic txn(input int g, input int p, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] wd, input int D, input logic [DW-1:0] exp_rd,
                       input string nm);
        @(posedge clk); #1;
        drive(g, p, a, we, wd);
        for (int k = 0; k <= D + 1; k++) begin
            @(negedge clk);
            chk({nm, "_ram_en"}, 32'(ram_en[g]), 32'(k == 1));
            chk({nm, "_ram_we"}, 32'(ram_we[g]), 32'(k == 1 && we));
            chk({nm, "_busy"}, 32'(busy[g]), 32'(k >= 1 && k <= D));
            chk({nm, "_done"}, 32'(done_of(g, p)), 32'(k == D));
            if (k == 1) chk({nm, "_ram_addr"}, 32'(ram_addr[g]), 32'(a));
            if (k == 1 && we) chk({nm, "_ram_wdata"}, 32'(ram_wdata[g]), 32'(wd));
            if (k == D) chk({nm, "_rdata"}, 32'(rdata[g]), 32'(exp_rd));
            @(posedge clk); #1;
            if (k == D) drop(g, p);
        end
    endtask

    task automatic wait_done(input int g, input int p, input int maxc, input string nm);
        bit seen = 0;
        for (int t = 0; t < maxc && !seen; t++) begin
            @(negedge clk);
            seen = done_of(g, p);
            @(posedge clk); #1;
        end
        chk({nm, "_seen"}, 32'(seen), 32'd1);
        drop(g, p);
    endtask

    task automatic chk_zero(input int g, input string nm);
        chk({nm, "_busy"}, 32'(busy[g]), 32'd0);
        chk({nm, "_en_we"}, 32'({ram_en[g], ram_we[g]}), 32'd0);
        chk({nm, "_dones"}, 32'({l_done[g], d_done[g], f_done[g]}), 32'd0);
        chk({nm, "_rdata"}, 32'(rdata[g]), 32'd0);
        chk({nm, "_ram_addr"}, 32'(ram_addr[g]), 32'd0);
        chk({nm, "_ram_wdata"}, 32'(ram_wdata[g]), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int seen_ord[$];
        int exp_ord[4];
`ifdef MEM_ARB_RR_EN
        exp_ord = '{2, 1, 0, 2};
`else
        exp_ord = '{2, 2, 2, 2};
`endif
        for (int g = 0; g < 2; g++) begin
            f_addr[g] = '0; d_addr[g] = '0; l_addr[g] = '0;
            d_wdata[g] = '0; l_wdata[g] = '0;
            for (int a = 0; a < 256; a++) preload(g, 8'(a), {8'(a), 8'(~a)});
        end
        preload(0, 8'h10, 16'h1234);
        preload(1, 8'h05, 16'h00A5);
        preload(1, 8'h41, 16'h4141);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        @(posedge clk); #1;
        rst = 1'b0;

        // all three requests held: arbitration order on instance 0
        drive(0, 2, 8'h50, 1'b1, 16'h5050);
        drive(0, 1, 8'h51, 1'b0, 16'h0000);
        drive(0, 0, 8'h52, 1'b0, 16'h0000);
        for (int t = 0; t < 40 && seen_ord.size() < 4; t++) begin
            @(negedge clk);
            if (l_done[0]) seen_ord.push_back(2);
            else if (d_done[0]) seen_ord.push_back(1);
            else if (f_done[0]) seen_ord.push_back(0);
            @(posedge clk); #1;
        end
        drop(0, 0); drop(0, 1); drop(0, 2);
        chk("prio_count", 32'(seen_ord.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_ord.size(); i++)
            chk("prio_order", 32'(seen_ord[i]), 32'(exp_ord[i]));
        repeat (6) @(posedge clk);
        #1;

        // RAM_LAT=1: fetch read, data store, read-back of the store
        txn(0, 0, 8'h10, 1'b0, 16'h0000, 3, 16'h1234, "fetch_l1");
        txn(0, 1, 8'h20, 1'b1, 16'hBEEF, 2, 16'h1234, "store_l1");
        txn(0, 0, 8'h20, 1'b0, 16'h0000, 3, 16'hBEEF, "rdback_l1");

        // RAM_LAT=3: fetch read
        txn(1, 0, 8'h05, 1'b0, 16'h0000, 5, 16'h00A5, "fetch_l3");

        // reset during WAIT of a RAM_LAT=3 read (cycle 2)
        @(posedge clk); #1;
        drive(1, 0, 8'h05, 1'b0, 16'h0000);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mrst_issue", 32'(ram_en[1]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drop(1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero(1, "mrst");
        for (int k = 4; k <= 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mrst_no_done", 32'(f_done[1]), 32'd0);
            chk("mrst_idle", 32'(busy[1]), 32'd0);
        end

        // store and fetch together: store first, fetch granted at cycle 3
        @(posedge clk); #1;
        drive(1, 1, 8'h40, 1'b1, 16'h5A5A);
        drive(1, 0, 8'h41, 1'b0, 16'h0000);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            chk("sf_data_done", 32'(d_done[1]), 32'(k == 2));
            chk("sf_fetch_done", 32'(f_done[1]), 32'(k == 8));
            chk("sf_ram_en", 32'(ram_en[1]), 32'(k == 1 || k == 4));
            if (k == 1) chk("sf_first_addr", 32'(ram_addr[1]), 32'h40);
            if (k == 8) chk("sf_rdata", 32'(rdata[1]), 32'h4141);
            @(posedge clk); #1;
            if (k == 2) drop(1, 1);
            if (k == 8) drop(1, 0);
        end

        // data request arriving during a fetch WAIT is held off until IDLE
        @(posedge clk); #1;
        drive(1, 0, 8'h07, 1'b0, 16'h0000);
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            chk("late_ram_en", 32'(ram_en[1]), 32'(k == 1 || k == 7));
            chk("late_fetch_done", 32'(f_done[1]), 32'(k == 5));
            chk("late_busy", 32'(busy[1]), 32'(k != 0 && k != 6));
            if (k == 7) chk("late_ram_addr", 32'(ram_addr[1]), 32'h30);
            @(posedge clk); #1;
            if (k == 1) drive(1, 1, 8'h30, 1'b0, 16'h0000);
            if (k == 5) drop(1, 0);
        end
        wait_done(1, 1, 10, "late_data");

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM access sequencer for the 16-bit core. It shares one RAM port between three requesters: instruction fetch (the control unit's fetch pulse path), data load/store from execution, and the external program loader. It grants one request at a time, issues the RAM cycle, waits out the read latency, and returns a one-cycle done strobe. The fetch done strobe is what drives the instruction register's RAM-out enable.

## Interface
- DWIDTH, 16, data width
- AWIDTH, 8, address width (matches the 8-bit instruction offset field)
- RAM_LAT, 1, RAM read latency in cycles; legal range 1..7
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-high (asserted = 1); the name is kept for port consistency across the core
- fetch_req  in  1  fetch read request, level, held until fetch_done
- fetch_addr  in  AWIDTH  fetch address
- fetch_done  out  1  one-cycle strobe; rdata is valid in the same cycle
- data_req  in  1  load/store request, level
- data_we  in  1  1 = store, 0 = load
- data_addr  in  AWIDTH  data address
- data_wdata  in  DWIDTH  store data
- data_done  out  1  one-cycle completion strobe
- ldr_req  in  1  loader write request (write-only port), level
- ldr_addr  in  AWIDTH  loader address
- ldr_wdata  in  DWIDTH  loader data
- ldr_done  out  1  one-cycle completion strobe
- rdata  out  DWIDTH  last read data; held until the next read completes
- busy  out  1  1 whenever state != IDLE
- ram_en, ram_we  out  1  RAM strobe and write enable
- ram_addr  out  AWIDTH  RAM address
- ram_wdata  out  DWIDTH  RAM write data
- ram_rdata  in  DWIDTH  RAM read data, valid RAM_LAT cycles after the ram_en cycle

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** sample the requests. If any are high, pick a winner and latch its index, address, we and wdata. Loader requests are always writes. Go to ISSUE. If no request is high, stay in IDLE.
- **ISSUE:** ram_en=1 for exactly one cycle, driven from the latched values.
  - On a write, go to RESP.
  - On a read, load the counter with RAM_LAT and go to WAIT.
- **WAIT:** decrement the counter each cycle. In the cycle the counter reaches 1, capture ram_rdata into rdata and go to RESP.
- **RESP:** pulse the winner's done strobe for one cycle, then go to IDLE.
- Requests are only sampled in IDLE. A request that arrives while busy waits, and busy stays 1.
- Requester rule: deassert req at the clock edge that ends the done cycle. A req that is still high in the following IDLE cycle is a new request.
- The latched address and data are used throughout. Changes on the request inputs after the grant are ignored.
- Fixed priority: ldr > data > fetch.
- Writes leave rdata unchanged.
- A store and a fetch requested together: the store completes first.
- ram_we is 0 except in ISSUE on a write. ram_addr and ram_wdata may hold their last value otherwise.

## Timing
- Reset value of every output is 0: all done strobes, rdata, busy, ram_en, ram_we, ram_addr, ram_wdata. The FSM resets to IDLE and the RR pointer resets to fetch.
- If reset is asserted mid-operation, the next cycle is IDLE with no done pulse and no RAM strobe. The in-flight request is dropped and the requester must reissue.
- Latency is counted from the IDLE cycle in which the request is sampled (cycle 0):
  - ram_en in cycle 1.
  - Write done in cycle 2.
  - Read: WAIT spans cycles 2..1+RAM_LAT; capture at the end of cycle 1+RAM_LAT; done in cycle 2+RAM_LAT.
- Minimum spacing between grants: write 3 cycles; read 3+RAM_LAT cycles.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - Priority rotates cyclically in the order ldr → data → fetch → ldr.
  - The last-granted requester becomes lowest priority.
  - The pointer resets to "last granted = fetch", so the first order after reset is ldr > data > fetch.
  - The pointer updates only on a grant.
- MEM_ARB_RR_EN undefined: fixed priority ldr > data > fetch. No pointer register exists.

## Structure
- Package mem_arb_pkg holds:
  - State encodings IDLE=0, ISSUE=1, WAIT=2, RESP=3 (2 bits).
  - Requester indices REQ_FETCH=0, REQ_DATA=1, REQ_LDR=2.
  - The 3-bit latency counter width.
- Sub-module mem_arb_pick is a combinational winner select.
  - Inputs: the 3 requests and the last-granted index.
  - Output: a one-hot grant.
  - It contains both the fixed and the RR logic under MEM_ARB_RR_EN.
- mem_arbiter contains the FSM, the latch registers, the counter and the pointer.

## Test plan
- Fetch read alone, addr 0x10, RAM model returns 0x1234, RAM_LAT=1 → ram_en only in cycle 1 with ram_addr=0x10; fetch_done in cycle 3; rdata=0x1234; busy=1 in cycles 1–3.
- Data store, addr 0x20, wdata 0xBEEF → ram_en=ram_we=1 in cycle 1; data_done in cycle 2; rdata unchanged.
- All three reqs held high and reissued immediately after each done → fixed priority: ldr, ldr, ldr…; with MEM_ARB_RR_EN: ldr, data, fetch, ldr.
- RAM_LAT=3, fetch read at 0x05, model returns 0x00A5 in cycle 4 → fetch_done in cycle 5 with rdata=0x00A5; no done strobe before cycle 5.
- rst_n=1 in cycle 2 of a RAM_LAT=3 read → IDLE next cycle; all outputs 0; no fetch_done pulse.
- data_req rises during a fetch WAIT → not granted until IDLE; ram_en for the data request occurs exactly 2 cycles after fetch_done.
